// File: rtl/cache_monitor_ctrl.sv
// Sequences core loads/stores and ldrex/strex into cache line accesses
// and exclusive-monitor strobes.
module cache_monitor_ctrl #(
    parameter int WORD_BITS = 32,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [29:0]          core_address,
    input  logic                 core_read,
    input  logic                 core_write,
    input  logic                 core_lock,
    input  logic [WORD_BITS-1:0] core_writedata,
    output logic                 core_waitrequest,
    output logic [WORD_BITS-1:0] core_readdata,
    output logic [1:0]           core_response,
    output logic [27:0]          cache_address,
    output logic                 cache_read,
    output logic                 cache_write,
    output logic [LINE_BITS-1:0] cache_writedata,
    input  logic [LINE_BITS-1:0] cache_readdata,
    input  logic                 cache_waitrequest,
    output logic [LINE_BITS-1:0] data_rd,
    output logic                 monitor_acquire,
    output logic                 monitor_release,
    output logic                 monitor_fail,
    input  logic                 monitor_commit,
    input  logic [LINE_BITS-1:0] monitor_update
);
    localparam int WORDS = LINE_BITS / WORD_BITS;

    typedef enum logic [2:0] {
        IDLE, READ, ACQUIRE, CHECK, WRITE, DONE
    } state_t;

    state_t                 state_q;
    logic [29:0]            addr_q;
    logic [WORD_BITS-1:0]   wdata_q;
    logic                   lock_q;
    logic                   write_q;
    logic                   fail_q;
    logic [LINE_BITS-1:0]   line_q;
    logic [LINE_BITS-1:0]   wline_q;
    logic [WORD_BITS-1:0]   rd_word;
    logic [LINE_BITS-1:0]   merged;
    logic                   cache_ack;

    assign cache_ack = !cache_waitrequest;

    always_comb begin
        rd_word = '0;
        merged  = line_q;
        for (int i = 0; i < WORDS; i++) begin
            if (addr_q[1:0] == 2'(i)) begin
                rd_word = line_q[i*WORD_BITS +: WORD_BITS];
                merged[i*WORD_BITS +: WORD_BITS] = wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            fail_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (core_read || core_write) state_q <= READ;
                end
                READ: begin
                    if (cache_ack) begin
                        if (write_q)     state_q <= CHECK;
                        else if (lock_q) state_q <= ACQUIRE;
                        else             state_q <= DONE;
                    end
                end
                ACQUIRE: state_q <= DONE;
                CHECK: begin
                    if (lock_q && !monitor_commit) begin
                        fail_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (cache_ack) state_q <= DONE;
                end
                DONE: begin
                    fail_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Request/line registers carry no reset; line_q must survive reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == IDLE && (core_read || core_write)) begin
                addr_q  <= core_address;
                wdata_q <= core_writedata;
                lock_q  <= core_lock;
                write_q <= !core_read;
            end
            if (state_q == READ && cache_ack) line_q <= cache_readdata;
            if (state_q == CHECK) wline_q <= lock_q ? monitor_update : merged;
        end
    end

    always_comb begin
        core_waitrequest = (state_q != DONE);
        core_readdata    = (state_q == DONE) ? rd_word : '0;
        core_response    = (state_q == DONE) ? {fail_q, 1'b0} : 2'b00;
        cache_read       = (state_q == READ);
        cache_write      = (state_q == WRITE);
        cache_address    = (cache_read || cache_write) ? addr_q[29:2] : '0;
        cache_writedata  = cache_write ? wline_q : '0;
        data_rd          = line_q;
        monitor_acquire  = (state_q == ACQUIRE);
        monitor_fail     = (state_q == CHECK) && lock_q && !monitor_commit;
        monitor_release  = monitor_fail ||
                           (cache_write && lock_q && cache_ack);
    end
endmodule

// File: doc/cache_monitor_ctrl.md
# cache_monitor_ctrl

Sequencer between one core's Avalon-style data port, the line-wide cache data port, and the exclusive monitor. It turns plain reads/writes and ldrex/strex (read/write with `core_lock`) into cache line reads, read-modify-write line writes, and single-cycle `monitor_acquire` / `monitor_release` / `monitor_fail` pulses. It is the only agent that drives the monitor's control strobes. The monitor always sees a stable, registered copy of the line (`data_rd`).

## Interface
- `WORD_BITS`, 32, core data width
- `LINE_BITS`, 128, cache line width; must equal 4×WORD_BITS
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, synchronous, active-high
- `core_address` in 30: word address; [1:0] is the word offset in the line
- `core_read`, `core_write`, `core_lock` in 1: Avalon request; lock marks ldrex/strex
- `core_writedata` in WORD_BITS: store data
- `core_waitrequest` out 1: low for exactly one cycle when the request completes
- `core_readdata` out WORD_BITS: selected word, valid while waitrequest low
- `core_response` out 2: 2'b00 OKAY, 2'b10 strex failed
- `cache_address` out 28: line address, core_address[29:2]
- `cache_read`, `cache_write` out 1: line request
- `cache_writedata` out LINE_BITS: line to write
- `cache_readdata` in LINE_BITS: line data, valid when cache_read && !cache_waitrequest
- `cache_waitrequest` in 1: cache stall
- `data_rd` out LINE_BITS: latched line (line_q) presented to monitor
- `monitor_acquire`, `monitor_release`, `monitor_fail` out 1: one-cycle pulses
- `monitor_commit` in 1: monitor permits the store
- `monitor_update` in LINE_BITS: monitor's merged line for the strex

## Operation
- States: IDLE, READ, ACQUIRE, CHECK, WRITE, DONE.
- IDLE:
  - On core_read || core_write, latch address, offset, writedata, lock and op into request registers; go to READ.
  - core_read has priority if both read and write are asserted.
- READ:
  - cache_read=1 until !cache_waitrequest; on that cycle, capture cache_readdata into line_q.
  - Next state: plain read → DONE; ldrex → ACQUIRE; any write → CHECK.
- ACQUIRE: monitor_acquire=1 for one cycle with data_rd=line_q; → DONE.
- CHECK (data_rd=line_q, combinational evaluation of monitor_commit):
  - Plain write: next line = line_q with the offset word replaced by writedata; → WRITE.
  - strex with commit=1: next line = monitor_update, registered; → WRITE.
  - strex with commit=0: monitor_fail=1 and monitor_release=1 this cycle; fail_q set; no cache write; → DONE.
- WRITE:
  - cache_write=1 with the registered line until !cache_waitrequest.
  - On that cycle, monitor_release=1, but only for a locked op.
  - → DONE.
- DONE:
  - core_waitrequest=0.
  - core_readdata = line_q word[offset].
  - core_response = {fail_q, 1'b0}.
  - fail_q is cleared on exit; → IDLE.
- Outputs are 0 outside the states named above; core_waitrequest=1 outside DONE.
- Plain writes never pulse any monitor strobe.
- monitor_acquire and monitor_release are never asserted in the same cycle.

## Timing
- Reset, sampled at an edge: next cycle state=IDLE, all strobes 0, core_waitrequest=1, core_response=00, fail_q=0, line_q unchanged. Reset mid-transaction abandons it; the cache request drops the following cycle.
- Latency, from request-sample edge to core_waitrequest low, with a zero-wait cache (W=0 extra stall cycles):
  - read: 2 cycles
  - ldrex: 3 cycles
  - write / committed strex: 4 cycles
  - failed strex: 3 cycles
- Each cache stall cycle adds 1 to these latencies.
- Core must hold its request until waitrequest low. A request still asserted in the IDLE cycle after DONE is a new transaction.
- line_q changes only on READ completion. data_rd is therefore stable across ACQUIRE and CHECK.
- cache_address and cache_writedata are stable for the whole cache request.

## Test plan
- Plain read, addr 0x11 (offset 01), cache line {D,C,B,A}, W=0: waitrequest low 2 cycles after sample, readdata=B, response 00, no monitor pulse.
- ldrex to offset 2 with W=3: cache_read high 4 cycles, then monitor_acquire exactly 1 cycle with data_rd={D,C,B,A}; readdata=C, waitrequest low 1 cycle later.
- strex, monitor_commit=1, monitor_update=0x4_3_2_1 pattern: cache_write of that line, monitor_release coincident with the write accept, response 00.
- strex, monitor_commit=0: monitor_fail and monitor_release both high for one cycle, cache_write never asserted, response 10 in DONE, next op response 00.
- Plain write 0xDEADBEEF to offset 3 over line {D,C,B,A}: cache_writedata={DEADBEEF,C,B,A}, no monitor strobes.
- rst asserted during WRITE stall: next cycle cache_write=0, monitor_release=0, waitrequest=1, state IDLE; a subsequent read completes normally.
